// File: rtl/dca_scalar_divider_pkg.sv
// Shared definitions for the DCA scalar divider: FSM state encoding.
package dca_scalar_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/dca_udiv_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The shifted partial remainder carries one extra bit because it can
// reach twice the divisor before the trial subtraction.
module dca_udiv_step #(
  parameter int BW = 32
) (
  input  logic [BW-1:0] rem_in,
  input  logic [BW-1:0] quo_in,
  input  logic [BW-1:0] divisor,
  output logic [BW-1:0] rem_out,
  output logic [BW-1:0] quo_out
);

  logic [BW:0]   rem_wide;
  logic [BW-1:0] diff;

  // Shift {rem,quo} left, trial-subtract, keep the difference when it fits.
  always_comb begin
    rem_wide = {rem_in, quo_in[BW-1]};
    diff     = rem_wide[BW-1:0] - divisor;
    if (rem_wide >= {1'b0, divisor}) begin
      rem_out = diff;
      quo_out = {quo_in[BW-2:0], 1'b1};
    end else begin
      rem_out = rem_wide[BW-1:0];
      quo_out = {quo_in[BW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/dca_scalar_divider.sv
// Iterative restoring divider for tensor scalars, signed or unsigned per op.
//
//   state | meaning
//   IDLE  | ready for an operand pair
//   BUSY  | one restoring step per enabled cycle, counter counts down
//   DONE  | result valid and held until the consumer takes it
module dca_scalar_divider
  import dca_scalar_divider_pkg::*;
#(
  parameter int BW_TENSOR_SCALAR = 32
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        enable,
  input  logic                        input_wvalid,
  output logic                        input_wready,
  input  logic                        input_signed,
  input  logic [BW_TENSOR_SCALAR-1:0] input_dividend,
  input  logic [BW_TENSOR_SCALAR-1:0] input_divisor,
  output logic                        output_rvalid,
  input  logic                        output_rready,
  output logic [BW_TENSOR_SCALAR-1:0] output_quotient,
  output logic [BW_TENSOR_SCALAR-1:0] output_remainder
);

  localparam int                BW       = BW_TENSOR_SCALAR;
  localparam int                COUNT_BW = $clog2(BW_TENSOR_SCALAR) + 1;
  localparam logic [BW-1:0]     MIN_VAL  = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0]     ALL_ONES = {BW{1'b1}};
  localparam logic [COUNT_BW-1:0] CNT_INIT = COUNT_BW'(BW);

  div_state_t          state_q, state_d;
  logic                load, step_en, finish;
  logic [COUNT_BW-1:0] cnt_q;
  logic [BW-1:0]       rem_q, quo_q, dvs_q;
  logic [BW-1:0]       step_rem, step_quo;
  logic [BW-1:0]       fix_q, fix_r;
  logic [BW-1:0]       out_q, out_r;
  logic                neg_q_f, neg_r_f, div0_f, ovf_f;
  logic                dvd_neg, dvs_neg;
  logic [BW-1:0]       dvd_mag, dvs_mag;

  // State register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake outputs and datapath strobes.
  always_comb begin
    state_d       = state_q;
    input_wready  = 1'b0;
    output_rvalid = 1'b0;
    load          = 1'b0;
    step_en       = 1'b0;
    finish        = 1'b0;
    case (state_q)
      IDLE: begin
        input_wready = 1'b1;
        if (input_wvalid && enable) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (enable) begin
          step_en = 1'b1;
          if (cnt_q == COUNT_BW'(1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        output_rvalid = 1'b1;
        if (output_rready && enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes and sign flags for the accepted pair.
  always_comb begin
    dvd_neg = input_signed & input_dividend[BW-1];
    dvs_neg = input_signed & input_divisor[BW-1];
    dvd_mag = dvd_neg ? -input_dividend : input_dividend;
    dvs_mag = dvs_neg ? -input_divisor  : input_divisor;
  end

  dca_udiv_step #(.BW(BW)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix-up of the final step, then special-case overrides. With a zero
  // divisor the remainder naturally ends up as the original dividend.
  always_comb begin
    fix_q = neg_q_f ? -step_quo : step_quo;
    fix_r = neg_r_f ? -step_rem : step_rem;
    if (div0_f) begin
      fix_q = ALL_ONES;
    end else if (ovf_f) begin
      fix_q = MIN_VAL;
      fix_r = '0;
    end
  end

  // Datapath registers: latch on accept, iterate in BUSY, capture result.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q_f <= 1'b0;
      neg_r_f <= 1'b0;
      div0_f  <= 1'b0;
      ovf_f   <= 1'b0;
      out_q   <= '0;
      out_r   <= '0;
    end else if (load) begin
      cnt_q   <= CNT_INIT;
      rem_q   <= '0;
      quo_q   <= dvd_mag;
      dvs_q   <= dvs_mag;
      neg_q_f <= dvd_neg ^ dvs_neg;
      neg_r_f <= dvd_neg;
      div0_f  <= (input_divisor == '0);
      ovf_f   <= input_signed && (input_dividend == MIN_VAL) && (input_divisor == ALL_ONES);
    end else if (step_en) begin
      cnt_q <= cnt_q - 1'b1;
      rem_q <= step_rem;
      quo_q <= step_quo;
      if (finish) begin
        out_q <= fix_q;
        out_r <= fix_r;
      end
    end
  end

  assign output_quotient  = out_q;
  assign output_remainder = out_r;

endmodule

// File: tb/tb_dca_scalar_divider.sv
// Directed bench for dca_scalar_divider. Latency counts the accept cycle as
// cycle 0; rvalid is expected to be observed in cycle 33 for a 32-bit op.
module tb_dca_scalar_divider;

  localparam int BW = 32;

  logic          clk;
  logic          rstnn;
  logic          enable;
  logic          input_wvalid;
  logic          input_wready;
  logic          input_signed;
  logic [BW-1:0] input_dividend;
  logic [BW-1:0] input_divisor;
  logic          output_rvalid;
  logic          output_rready;
  logic [BW-1:0] output_quotient;
  logic [BW-1:0] output_remainder;

  int errors = 0;
  int checks = 0;

  dca_scalar_divider #(.BW_TENSOR_SCALAR(BW)) dut (
    .clk              (clk),
    .rstnn            (rstnn),
    .enable           (enable),
    .input_wvalid     (input_wvalid),
    .input_wready     (input_wready),
    .input_signed     (input_signed),
    .input_dividend   (input_dividend),
    .input_divisor    (input_divisor),
    .output_rvalid    (output_rvalid),
    .output_rready    (output_rready),
    .output_quotient  (output_quotient),
    .output_remainder (output_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    input_signed   = sgn;
    input_dividend = a;
    input_divisor  = b;
    input_wvalid   = 1'b1;
    @(posedge clk); #1;
    input_wvalid   = 1'b0;
  endtask

  // Waits for rvalid with a cycle bound; optionally drops enable for
  // stall_len cycles starting at BUSY cycle stall_at.
  task automatic wait_done(input string tag, input int exp_lat, input int stall_at, input int stall_len);
    int lat;
    int wr_hi;
    lat   = 1;
    wr_hi = 0;
    while (output_rvalid !== 1'b1 && lat < 200) begin
      if (input_wready !== 1'b0) wr_hi++;
      if (stall_len > 0 && lat == stall_at) enable = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) enable = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    enable = 1'b1;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " wready in busy"}, wr_hi, 0);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] q, input logic [31:0] r);
    check({tag, " quotient"}, output_quotient, q);
    check({tag, " remainder"}, output_remainder, r);
    @(posedge clk); #1;
    check({tag, " rvalid drop"}, output_rvalid, 1'b0);
  endtask

  initial begin
    int bad;
    rstnn          = 1'b0;
    enable         = 1'b1;
    input_wvalid   = 1'b0;
    input_signed   = 1'b0;
    input_dividend = '0;
    input_divisor  = '0;
    output_rready  = 1'b1;
    #12;
    check("reset wready", input_wready, 1'b1);
    check("reset rvalid", output_rvalid, 1'b0);
    check("reset quotient", output_quotient, 32'h0);
    check("reset remainder", output_remainder, 32'h0);
    #10 rstnn = 1'b1;
    @(posedge clk); #1;

    start_op(1'b0, 32'd100, 32'd7);
    wait_done("u100/7", 33, 0, 0);
    finish_op("u100/7", 32'd14, 32'd2);

    start_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("s-7/2", 33, 0, 0);
    finish_op("s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    start_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done("s7/-2", 33, 0, 0);
    finish_op("s7/-2", 32'hFFFF_FFFD, 32'h0000_0001);

    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("s-100/7", 33, 0, 0);
    finish_op("s-100/7", 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    start_op(1'b0, 32'h1234_5678, 32'h0);
    wait_done("u div0", 33, 0, 0);
    finish_op("u div0", 32'hFFFF_FFFF, 32'h1234_5678);

    start_op(1'b1, 32'h1234_5678, 32'h0);
    wait_done("s div0", 33, 0, 0);
    finish_op("s div0", 32'hFFFF_FFFF, 32'h1234_5678);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s ovf", 33, 0, 0);
    finish_op("s ovf", 32'h8000_0000, 32'h0);

    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("u min/ones", 33, 0, 0);
    finish_op("u min/ones", 32'h0, 32'h8000_0000);

    // Backpressure: result held, new operands ignored while DONE.
    output_rready = 1'b0;
    start_op(1'b0, 32'd1000, 32'd10);
    wait_done("bp", 33, 0, 0);
    check("bp quotient", output_quotient, 32'd100);
    check("bp remainder", output_remainder, 32'd0);
    input_wvalid   = 1'b1;
    input_dividend = 32'd5;
    input_divisor  = 32'd1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (output_rvalid !== 1'b1 || output_quotient !== 32'd100 ||
          output_remainder !== 32'd0 || input_wready !== 1'b0) bad++;
    end
    check("bp hold", bad, 0);
    output_rready = 1'b1;
    @(posedge clk); #1;
    check("bp drained rvalid", output_rvalid, 1'b0);
    check("bp no accept in DONE", input_wready, 1'b1);
    input_wvalid = 1'b0;

    // Enable stall of 5 cycles mid-BUSY.
    start_op(1'b0, 32'd1000000, 32'd7);
    wait_done("stall", 38, 10, 5);
    finish_op("stall", 32'd142857, 32'd1);

    // Leave a nonzero result in the output registers before the reset test.
    start_op(1'b0, 32'd50, 32'd6);
    wait_done("pre-rst", 33, 0, 0);
    finish_op("pre-rst", 32'd8, 32'd2);

    // Asynchronous reset in BUSY cycle 12.
    start_op(1'b0, 32'h1234_5678, 32'd3);
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("rst busy wready", input_wready, 1'b0);
    #2 rstnn = 1'b0;
    #1;
    check("rst wready", input_wready, 1'b1);
    check("rst rvalid", output_rvalid, 1'b0);
    check("rst quotient", output_quotient, 32'h0);
    check("rst remainder", output_remainder, 32'h0);
    @(posedge clk); #1;
    rstnn = 1'b1;
    @(posedge clk); #1;
    check("post-rst rvalid", output_rvalid, 1'b0);
    check("post-rst wready", input_wready, 1'b1);

    start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_done("after rst", 33, 0, 0);
    finish_op("after rst", 32'h0FFF_FFFF, 32'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
